nano_mem_arbiter: RTL and testbench

Single-port memory arbiter for the nano4bit core. It shares one synchronous single-port RAM (1-cycle read latency) between the core's instruction port, the core's data port and an external host/loader port. All three slave-side ports use waitrequest handshakes: a requester holds its command until it samples waitrequest low. It sits between the core and the unified program/data RAM.

---
 rtl/nano_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_nano_mem_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nano_mem_arbiter.sv
// Single-port RAM arbiter for the nano4bit core: instruction, data and host ports share one
// synchronous RAM. Core group (D over I) and host alternate round-robin; reads take two cycles.
module nano_mem_arbiter #(
    parameter int unsigned WIDTHA = 12,
    parameter int unsigned WIDTHD = 16
) (
    input  logic              clock,
    input  logic              areset_n,

    input  logic [WIDTHA-1:0] i_address,
    input  logic              i_read,
    output logic [WIDTHD-1:0] i_readdata,
    output logic              i_waitrequest,

    input  logic [WIDTHA-1:0] d_address,
    input  logic [WIDTHD-1:0] d_writedata,
    input  logic              d_read,
    input  logic              d_write,
    output logic [WIDTHD-1:0] d_readdata,
    output logic              d_waitrequest,

    input  logic [WIDTHA-1:0] h_address,
    input  logic [WIDTHD-1:0] h_writedata,
    input  logic              h_read,
    input  logic              h_write,
    output logic [WIDTHD-1:0] h_readdata,
    output logic              h_waitrequest,

    output logic [WIDTHA-1:0] m_address,
    output logic [WIDTHD-1:0] m_writedata,
    output logic              m_read,
    output logic              m_write,
    input  logic [WIDTHD-1:0] m_readdata
);

    typedef enum logic {
        StIdle,
        StRdata
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnI,
        OwnD,
        OwnH
    } owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   rr_q, rr_d;

    logic d_req, h_req, core_req, host_wins;

    assign d_req     = d_read | d_write;
    assign h_req     = h_read | h_write;
    assign core_req  = d_req | i_read;
    // rr_q = 1 means the host has the next turn; a lone group always wins.
    assign host_wins = h_req & (rr_q | ~core_req);

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        m_address     = '0;
        m_writedata   = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        h_waitrequest = 1'b1;

        unique case (state_q)
            StIdle: begin
                owner_d = OwnNone;
                if (host_wins) begin
                    rr_d        = 1'b0;
                    m_address   = h_address;
                    m_writedata = h_writedata;
                    // A write wins over a simultaneous read on the same port.
                    if (h_write) begin
                        m_write       = 1'b1;
                        h_waitrequest = 1'b0;
                    end else begin
                        m_read  = 1'b1;
                        owner_d = OwnH;
                        state_d = StRdata;
                    end
                end else if (d_req) begin
                    rr_d        = 1'b1;
                    m_address   = d_address;
                    m_writedata = d_writedata;
                    if (d_write) begin
                        m_write       = 1'b1;
                        d_waitrequest = 1'b0;
                    end else begin
                        m_read  = 1'b1;
                        owner_d = OwnD;
                        state_d = StRdata;
                    end
                end else if (i_read) begin
                    rr_d      = 1'b1;
                    m_address = i_address;
                    m_read    = 1'b1;
                    owner_d   = OwnI;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                state_d = StIdle;
                owner_d = OwnNone;
                unique case (owner_q)
                    OwnI: begin
                        m_address     = i_address;
                        i_waitrequest = 1'b0;
                    end
                    OwnD: begin
                        m_address     = d_address;
                        d_waitrequest = 1'b0;
                    end
                    OwnH: begin
                        m_address     = h_address;
                        h_waitrequest = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: state_d = StIdle;
        endcase

        // Keep the RAM and requesters quiet while reset is held.
        if (!areset_n) begin
            m_read        = 1'b0;
            m_write       = 1'b0;
            i_waitrequest = 1'b1;
            d_waitrequest = 1'b1;
            h_waitrequest = 1'b1;
        end
    end

    assign i_readdata = m_readdata;
    assign d_readdata = m_readdata;
    assign h_readdata = m_readdata;

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Bench for nano_mem_arbiter: directed scenarios plus random traffic checked against a
// transaction-level memory model with latency bounds.
module tb_nano_mem_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    logic          clock = 1'b0;
    logic          areset_n = 1'b0;
    logic [AW-1:0] i_address, d_address, h_address, m_address;
    logic [DW-1:0] d_writedata, h_writedata, m_writedata, m_readdata;
    logic [DW-1:0] i_readdata, d_readdata, h_readdata;
    logic          i_read, d_read, d_write, h_read, h_write;
    logic          i_waitrequest, d_waitrequest, h_waitrequest, m_read, m_write;

    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail = 0;

    // Reference state for the random test: expected RAM contents of addresses 0..15.
    logic [DW-1:0] gold [16];
    logic          act [3];
    logic          is_wr [3];
    logic          both [3];
    logic [3:0]    t_addr [3];
    logic [DW-1:0] t_data [3];
    int            age [3];

    always #5 clock = ~clock;

    nano_mem_arbiter #(.WIDTHA(AW), .WIDTHD(DW)) dut (
        .clock         (clock),
        .areset_n      (areset_n),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_readdata    (i_readdata),
        .i_waitrequest (i_waitrequest),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_readdata    (d_readdata),
        .d_waitrequest (d_waitrequest),
        .h_address     (h_address),
        .h_writedata   (h_writedata),
        .h_read        (h_read),
        .h_write       (h_write),
        .h_readdata    (h_readdata),
        .h_waitrequest (h_waitrequest),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_readdata    (m_readdata)
    );

    // Synchronous single-port RAM with a backdoor preload port.
    always @(posedge clock) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (m_write) begin
            ram[m_address] <= m_writedata;
        end
        if (m_read) m_readdata <= ram[m_address];
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        i_read = 0; d_read = 0; d_write = 0; h_read = 0; h_write = 0;
        i_address = '0; d_address = '0; h_address = '0;
        d_writedata = '0; h_writedata = '0;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
        bd_we = 1; bd_addr = a; bd_data = v;
        next_cycle();
        bd_we = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset_n = 0;
        next_cycle();
        next_cycle();
        areset_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        areset_n = 0;
        i_read = 1; d_read = 1; d_write = 1; h_read = 1; h_write = 1;
        i_address = 12'h011; d_address = 12'h033; h_address = 12'h022;
        for (int c = 0; c < 3; c++) begin
            mid();
            n_checks++;
            if ({i_waitrequest, d_waitrequest, h_waitrequest} !== 3'b111) begin
                n_fail++;
                $display("FAIL reset_wait cyc %0d got %b want 111", c,
                         {i_waitrequest, d_waitrequest, h_waitrequest});
            end
            n_checks++;
            if ({m_read, m_write} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mem cyc %0d got %b want 00", c, {m_read, m_write});
            end
            next_cycle();
        end
        areset_n = 1;
        clear_inputs();
        i_read = 1; h_read = 1; i_address = 12'h011; h_address = 12'h022;
        mid();
        n_checks++;
        if (m_read !== 1'b1 || m_address !== 12'h011) begin
            n_fail++;
            $display("FAIL reset_first_grant got rd=%b addr=%h want rd=1 addr=011",
                     m_read, m_address);
        end
        next_cycle();
        clear_inputs();
        mid();
        n_checks++;
        if (i_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dropped_read got i_wait=%b want 0", i_waitrequest);
        end
        next_cycle();
    endtask

    task automatic test_fetch();
        bd_write(12'h004, 16'hABCD);
        clear_inputs();
        i_read = 1; i_address = 12'h004;
        mid();
        n_checks++;
        if (m_read !== 1'b1 || m_address !== 12'h004 || i_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_c0 got rd=%b addr=%h iw=%b want 1 004 1",
                     m_read, m_address, i_waitrequest);
        end
        next_cycle();
        mid();
        n_checks++;
        if (i_waitrequest !== 1'b0 || i_readdata !== 16'hABCD || m_read !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_c1 got iw=%b data=%h rd=%b want 0 abcd 0",
                     i_waitrequest, i_readdata, m_read);
        end
        next_cycle();
        mid();
        n_checks++;
        if (m_read !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_c2 got rd=%b want 1", m_read);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_write_read();
        clear_inputs();
        d_write = 1; d_address = 12'h3E1; d_writedata = 16'h1234;
        mid();
        n_checks++;
        if (m_write !== 1'b1 || d_waitrequest !== 1'b0 || m_address !== 12'h3E1 ||
            m_writedata !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_cycle got wr=%b dw=%b addr=%h wd=%h want 1 0 3e1 1234",
                     m_write, d_waitrequest, m_address, m_writedata);
        end
        next_cycle();
        d_write = 0; d_read = 1;
        mid();
        n_checks++;
        if (m_read !== 1'b1 || d_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_grant got rd=%b dw=%b want 1 1", m_read, d_waitrequest);
        end
        next_cycle();
        mid();
        n_checks++;
        if (d_waitrequest !== 1'b0 || d_readdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL rd_data got dw=%b data=%h want 0 1234", d_waitrequest, d_readdata);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_contention();
        logic exp_rd, exp_iw, exp_hw;
        logic [AW-1:0] exp_a;
        do_reset();
        bd_write(12'h010, 16'h1111);
        bd_write(12'h020, 16'h2222);
        clear_inputs();
        i_read = 1; h_read = 1; i_address = 12'h010; h_address = 12'h020;
        for (int c = 0; c < 8; c++) begin
            exp_rd = (c % 2 == 0);
            exp_a  = (c % 4 == 0) ? 12'h010 : 12'h020;
            exp_iw = !(c == 1 || c == 5);
            exp_hw = !(c == 3 || c == 7);
            mid();
            n_checks++;
            if (m_read !== exp_rd || (exp_rd && m_address !== exp_a)) begin
                n_fail++;
                $display("FAIL cont_grant cyc %0d got rd=%b addr=%h want rd=%b addr=%h",
                         c, m_read, m_address, exp_rd, exp_a);
            end
            n_checks++;
            if (i_waitrequest !== exp_iw || h_waitrequest !== exp_hw) begin
                n_fail++;
                $display("FAIL cont_wait cyc %0d got iw=%b hw=%b want %b %b",
                         c, i_waitrequest, h_waitrequest, exp_iw, exp_hw);
            end
            if (!exp_iw) begin
                n_checks++;
                if (i_readdata !== 16'h1111) begin
                    n_fail++;
                    $display("FAIL cont_idata cyc %0d got %h want 1111", c, i_readdata);
                end
            end
            if (!exp_hw) begin
                n_checks++;
                if (h_readdata !== 16'h2222) begin
                    n_fail++;
                    $display("FAIL cont_hdata cyc %0d got %h want 2222", c, h_readdata);
                end
            end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_priority();
        bd_write(12'h030, 16'h3333);
        bd_write(12'h040, 16'h4444);
        clear_inputs();
        d_read = 1; d_address = 12'h030; i_read = 1; i_address = 12'h040;
        mid();
        n_checks++;
        if (m_read !== 1'b1 || m_address !== 12'h030) begin
            n_fail++;
            $display("FAIL prio_c0 got rd=%b addr=%h want 1 030", m_read, m_address);
        end
        next_cycle();
        h_write = 1; h_address = 12'h050; h_writedata = 16'h5A5A;
        mid();
        n_checks++;
        if (d_waitrequest !== 1'b0 || d_readdata !== 16'h3333 || h_waitrequest !== 1'b1 ||
            i_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_c1 got dw=%b data=%h hw=%b iw=%b want 0 3333 1 1",
                     d_waitrequest, d_readdata, h_waitrequest, i_waitrequest);
        end
        next_cycle();
        d_read = 0;
        mid();
        n_checks++;
        if (h_waitrequest !== 1'b0 || m_write !== 1'b1 || m_address !== 12'h050 ||
            i_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_c2 got hw=%b wr=%b addr=%h iw=%b want 0 1 050 1",
                     h_waitrequest, m_write, m_address, i_waitrequest);
        end
        next_cycle();
        h_write = 0;
        mid();
        n_checks++;
        if (m_read !== 1'b1 || m_address !== 12'h040) begin
            n_fail++;
            $display("FAIL prio_c3 got rd=%b addr=%h want 1 040", m_read, m_address);
        end
        next_cycle();
        mid();
        n_checks++;
        if (i_waitrequest !== 1'b0 || i_readdata !== 16'h4444) begin
            n_fail++;
            $display("FAIL prio_c4 got iw=%b data=%h want 0 4444", i_waitrequest, i_readdata);
        end
        next_cycle();
        clear_inputs();
        d_read = 1; d_address = 12'h050;
        next_cycle();
        mid();
        n_checks++;
        if (d_waitrequest !== 1'b0 || d_readdata !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL prio_hwrite_landed got dw=%b data=%h want 0 5a5a",
                     d_waitrequest, d_readdata);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        bd_write(12'h060, 16'h6666);
        clear_inputs();
        h_read = 1; h_address = 12'h060;
        mid();
        n_checks++;
        if (m_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_grant got rd=%b want 1", m_read);
        end
        next_cycle();
        areset_n = 0;
        mid();
        n_checks++;
        if (h_waitrequest !== 1'b1 || m_read !== 1'b0 || m_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_abort got hw=%b rd=%b wr=%b want 1 0 0",
                     h_waitrequest, m_read, m_write);
        end
        next_cycle();
        areset_n = 1;
        mid();
        n_checks++;
        if (m_read !== 1'b1 || m_address !== 12'h060 || h_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_regrant got rd=%b addr=%h hw=%b want 1 060 1",
                     m_read, m_address, h_waitrequest);
        end
        next_cycle();
        mid();
        n_checks++;
        if (h_waitrequest !== 1'b0 || h_readdata !== 16'h6666) begin
            n_fail++;
            $display("FAIL rmid_data got hw=%b data=%h want 0 6666", h_waitrequest, h_readdata);
        end
        next_cycle();
        clear_inputs();
    endtask

    // Random traffic: every completed read must return the latest completed write to that
    // address, and every transfer must finish within 3 cycles of its request.
    task automatic test_random();
        logic [DW-1:0] rd;
        logic [2:0]    w;
        for (int a = 0; a < 16; a++) begin
            gold[a] = DW'($urandom);
            bd_write(AW'(a), gold[a]);
        end
        for (int p = 0; p < 3; p++) begin
            act[p] = 0; is_wr[p] = 0; both[p] = 0; t_addr[p] = '0; t_data[p] = '0; age[p] = 0;
        end
        clear_inputs();
        for (int c = 0; c < 620; c++) begin
            if (c < 600) begin
                for (int p = 0; p < 3; p++) begin
                    // The core never issues I and D together.
                    if (!act[p] && $urandom_range(0, 2) != 0 &&
                        !(p == 0 && act[1]) && !(p == 1 && act[0])) begin
                        act[p]    = 1;
                        is_wr[p]  = (p != 0) && ($urandom_range(0, 1) == 1);
                        both[p]   = ($urandom_range(0, 3) == 0);
                        t_addr[p] = 4'($urandom);
                        t_data[p] = DW'($urandom);
                        age[p]    = 0;
                    end
                end
            end
            i_read      = act[0];
            i_address   = AW'(t_addr[0]);
            d_write     = act[1] && is_wr[1];
            d_read      = act[1] && (!is_wr[1] || both[1]);
            d_address   = AW'(t_addr[1]);
            d_writedata = t_data[1];
            h_write     = act[2] && is_wr[2];
            h_read      = act[2] && (!is_wr[2] || both[2]);
            h_address   = AW'(t_addr[2]);
            h_writedata = t_data[2];
            mid();
            w = {h_waitrequest, d_waitrequest, i_waitrequest};
            n_checks++;
            if ((!w[0] + !w[1] + !w[2]) > 1 || (m_read && m_write)) begin
                n_fail++;
                $display("FAIL rnd_exclusive cyc %0d got waits=%b rd=%b wr=%b",
                         c, w, m_read, m_write);
            end
            for (int p = 0; p < 3; p++) begin
                rd = (p == 0) ? i_readdata : (p == 1) ? d_readdata : h_readdata;
                if (!w[p]) begin
                    n_checks++;
                    if (!act[p]) begin
                        n_fail++;
                        $display("FAIL rnd_spurious port %0d cyc %0d got wait=0 want 1", p, c);
                    end else begin
                        if (age[p] > 3) begin
                            n_fail++;
                            $display("FAIL rnd_latency port %0d cyc %0d got %0d want <=3",
                                     p, c, age[p]);
                        end else if (!is_wr[p] && rd !== gold[t_addr[p]]) begin
                            n_fail++;
                            $display("FAIL rnd_rdata port %0d addr %h got %h want %h",
                                     p, t_addr[p], rd, gold[t_addr[p]]);
                        end
                        if (is_wr[p]) gold[t_addr[p]] = t_data[p];
                        act[p] = 0;
                    end
                end else if (act[p]) begin
                    age[p]++;
                    if (age[p] > 8) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rnd_timeout port %0d cyc %0d got no completion", p, c);
                        act[p] = 0;
                    end
                end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        next_cycle();
        test_reset();
        test_fetch();
        test_write_read();
        test_contention();
        test_priority();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
